// File: rtl/vedic_seq_mul.sv
// Sequential Urdhva-Tiryagbhyam multiplier: one 2x2 digit product per cycle, shift-accumulated.
// Optional VEDIC_ZERO_BYPASS_EN: zero operands skip the multiply phase and complete at the accepting edge.
module vedic_seq_mul #(
  parameter int WIDTH = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [WIDTH-1:0]     a,
  input  logic [WIDTH-1:0]     b,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [2*WIDTH-1:0]   product
);

  localparam int D     = WIDTH / 2;
  localparam int P     = D * D;
  localparam int ACC_W = 2 * WIDTH;
  localparam int IDX_W = (P > 1) ? $clog2(P) : 1;
  localparam logic [IDX_W-1:0] D_I  = IDX_W'(D);
  localparam logic [IDX_W-1:0] LAST = IDX_W'(P - 1);

  typedef enum logic [1:0] {IDLE, MUL, DONE} state_t;

  state_t             state, state_nxt;
  logic [ACC_W-1:0]   acc;
  logic [IDX_W-1:0]   idx;
  logic [WIDTH-1:0]   a_q, b_q;
  logic               accept;
  logic               zero_op;
  logic [IDX_W-1:0]   dig_i, dig_j;
  logic [IDX_W:0]     shift_dig;
  logic [1:0]         a_dig, b_dig;
  logic [3:0]         pp;
  logic [ACC_W-1:0]   pp_term;

  // Gate-level primitives: every AND is a NAND followed by a NAND used as an inverter.
  function automatic logic nand2(input logic x, input logic y);
    return ~(x & y);
  endfunction

  function automatic logic and2(input logic x, input logic y);
    logic n;
    n = nand2(x, y);
    return nand2(n, n);
  endfunction

  function automatic logic xor2(input logic x, input logic y);
    logic n;
    n = nand2(x, y);
    return nand2(nand2(x, n), nand2(y, n));
  endfunction

  // Exact 4-bit product of two 2-bit digits: cross terms half-added, carry merged into a1b1.
  function automatic logic [3:0] pp2x2(input logic [1:0] x, input logic [1:0] y);
    logic t10, t01, t11, c1;
    logic [3:0] p;
    t10  = and2(x[1], y[0]);
    t01  = and2(x[0], y[1]);
    t11  = and2(x[1], y[1]);
    c1   = and2(t10, t01);
    p[0] = and2(x[0], y[0]);
    p[1] = xor2(t10, t01);
    p[2] = xor2(t11, c1);
    p[3] = and2(t11, c1);
    return p;
  endfunction

`ifdef VEDIC_ZERO_BYPASS_EN
  assign zero_op = (a == '0) || (b == '0);
`else
  assign zero_op = 1'b0;
`endif

  assign accept = in_valid && (state == IDLE);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    case (state)
      IDLE: begin
        in_ready = 1'b1;
        if (in_valid) state_nxt = zero_op ? DONE : MUL;
      end
      MUL: begin
        if (idx == LAST) state_nxt = DONE;
      end
      DONE: begin
        out_valid = 1'b1;
        if (out_ready) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // idx walks the digit grid row-major: row = digit of a_q, column = digit of b_q.
  always_comb begin
    dig_i     = idx / D_I;
    dig_j     = idx % D_I;
    a_dig     = 2'(a_q >> {dig_i, 1'b0});
    b_dig     = 2'(b_q >> {dig_j, 1'b0});
    pp        = pp2x2(a_dig, b_dig);
    shift_dig = {1'b0, dig_i} + {1'b0, dig_j};
    pp_term   = ACC_W'(pp) << {shift_dig, 1'b0};
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      acc <= '0;
      idx <= '0;
      a_q <= '0;
      b_q <= '0;
    end else if (accept) begin
      acc <= '0;
      idx <= '0;
      a_q <= a;
      b_q <= b;
    end else if (state == MUL) begin
      acc <= acc + pp_term;
      idx <= idx + 1'b1;
    end
  end

  // acc is frozen outside MUL, so the product stays stable while the sink stalls.
  assign product = out_valid ? acc : '0;

endmodule

// File: tb/tb_vedic_seq_mul.sv
// Directed bench for vedic_seq_mul: WIDTH=4 instance for protocol cases, WIDTH=8 instance for wide products.
module tb_vedic_seq_mul;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid, in_ready, out_valid, out_ready;
  logic [3:0]  a, b;
  logic [7:0]  product;

  logic        in_valid8, in_ready8, out_valid8, out_ready8;
  logic [7:0]  a8, b8;
  logic [15:0] product8;

  int chk_cnt = 0;
  int err_cnt = 0;

`ifdef VEDIC_ZERO_BYPASS_EN
  localparam int ZERO_LAT = 0;
`else
  localparam int ZERO_LAT = 4;
`endif

  always #5 clk = ~clk;

  vedic_seq_mul #(.WIDTH(4)) dut4 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .a(a), .b(b), .out_valid(out_valid), .out_ready(out_ready), .product(product)
  );

  vedic_seq_mul #(.WIDTH(8)) dut8 (
    .clk(clk), .rst(rst), .in_valid(in_valid8), .in_ready(in_ready8),
    .a(a8), .b(b8), .out_valid(out_valid8), .out_ready(out_ready8), .product(product8)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    chk_cnt++;
    if (got !== exp) begin
      err_cnt++;
      $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic accept(input logic [3:0] av, input logic [3:0] bv);
    a = av;
    b = bv;
    in_valid = 1'b1;
    check("accept_in_ready", 32'(in_ready), 32'd1);
    tick();
    in_valid = 1'b0;
  endtask

  // Counts edges after the accepting edge until out_valid; in_ready must stay low meanwhile.
  task automatic wait_out(input string tag, input int exp_lat, input logic [7:0] exp_prod);
    int cnt;
    logic busy_ok;
    cnt = 0;
    busy_ok = 1'b1;
    while (!out_valid && cnt < 40) begin
      if (in_ready) busy_ok = 1'b0;
      tick();
      cnt++;
    end
    if (in_ready) busy_ok = 1'b0;
    check({tag, "_valid"}, 32'(out_valid), 32'd1);
    check({tag, "_latency"}, 32'(cnt), 32'(exp_lat));
    check({tag, "_product"}, 32'(product), 32'(exp_prod));
    check({tag, "_in_ready_low"}, 32'(busy_ok), 32'd1);
  endtask

  task automatic run8(input logic [7:0] av, input logic [7:0] bv, input logic [15:0] exp_prod);
    int cnt;
    a8 = av;
    b8 = bv;
    in_valid8 = 1'b1;
    check("w8_in_ready", 32'(in_ready8), 32'd1);
    tick();
    in_valid8 = 1'b0;
    cnt = 0;
    while (!out_valid8 && cnt < 60) begin
      tick();
      cnt++;
    end
    check("w8_latency", 32'(cnt), 32'd16);
    check("w8_product", 32'(product8), 32'(exp_prod));
    tick();
    check("w8_drained", 32'(out_valid8), 32'd0);
  endtask

  initial begin
    logic never_valid;
    rst = 1'b1;
    in_valid = 1'b0; out_ready = 1'b1; a = '0; b = '0;
    in_valid8 = 1'b0; out_ready8 = 1'b1; a8 = '0; b8 = '0;
    tick();
    check("rst_in_ready", 32'(in_ready), 32'd1);
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_product", 32'(product), 32'd0);
    check("rst_w8_in_ready", 32'(in_ready8), 32'd1);
    tick();
    rst = 1'b0;
    tick();

    // 15*15 = 225 at full latency, immediate handshake.
    accept(4'd15, 4'd15);
    wait_out("max", 4, 8'd225);
    tick();
    check("max_out_valid_clear", 32'(out_valid), 32'd0);
    check("max_in_ready_back", 32'(in_ready), 32'd1);

    // Back-to-back with in_valid held: inputs change during MUL must be ignored.
    a = 4'd9; b = 4'd6; in_valid = 1'b1;
    tick();
    a = 4'd3; b = 4'd2;
    wait_out("b2b_first", 4, 8'd54);
    tick();
    check("b2b_idle_ready", 32'(in_ready), 32'd1);
    tick();
    in_valid = 1'b0;
    wait_out("b2b_second", 4, 8'd6);
    tick();

    // Sink stall: product and out_valid hold until out_ready.
    out_ready = 1'b0;
    accept(4'd13, 4'd11);
    wait_out("stall", 4, 8'd143);
    for (int k = 0; k < 5; k++) begin
      tick();
      check("stall_hold_valid", 32'(out_valid), 32'd1);
      check("stall_hold_product", 32'(product), 32'd143);
    end
    out_ready = 1'b1;
    tick();
    check("stall_released", 32'(out_valid), 32'd0);
    check("stall_in_ready", 32'(in_ready), 32'd1);

    // Reset during the second MUL cycle aborts the operation.
    accept(4'd7, 4'd7);
    tick();
    rst = 1'b1;
    #1;
    check("abort_in_ready", 32'(in_ready), 32'd1);
    check("abort_out_valid", 32'(out_valid), 32'd0);
    check("abort_product", 32'(product), 32'd0);
    tick();
    rst = 1'b0;
    never_valid = 1'b1;
    for (int k = 0; k < 8; k++) begin
      tick();
      if (out_valid) never_valid = 1'b0;
    end
    check("abort_no_output", 32'(never_valid), 32'd1);
    accept(4'd2, 4'd3);
    wait_out("after_abort", 4, 8'd6);
    tick();

    // Zero operand and a few mixed-digit patterns.
    accept(4'd0, 4'd12);
    wait_out("zero", ZERO_LAT, 8'd0);
    tick();
    accept(4'd5, 4'd10);
    wait_out("mix_5x10", 4, 8'd50);
    tick();
    accept(4'd14, 4'd1);
    wait_out("mix_14x1", 4, 8'd14);
    tick();

    // Wide instance: 16 digit products.
    run8(8'd255, 8'd255, 16'd65025);
    run8(8'd200, 8'd100, 16'd20000);

    $display("Simulation finished: %0d checks, %0d errors", chk_cnt, err_cnt);
    $finish;
  end

endmodule
